speed_table_writer: RTL and testbench
=====================================

# speed_table_writer

Writer side of the scanner's speed/pattern table. It captures an 8-bit switch value on each debounced KEY press and writes it into the next slot of a small single-port synchronous RAM. It then reads the slot back and compares it against the captured value, reporting done or error. It sits between the board's KEY/SW inputs and the RAM write port; the LED scanner's clock divider reads the same table.

## Interface
- ADDR_W, 3: table address width; the table holds 2^ADDR_W entries.
- DATA_W, 8: entry width.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz). Must be ≥ 2.

- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- reset  in  1  synchronous, active-high reset.
- KEY_N  in  1  raw push button, active-low, asynchronous to CLOCK_50.
- SW  in  DATA_W  value to be written; sampled only on an accepted press.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data; valid 1 cycle after the address edge (registered address, unregistered q).
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  one-cycle pulse on a successful write and readback.
- error  out  1  sticky; set on a readback mismatch.
- full  out  1  sticky; set when the write pointer wraps.
- wr_ptr  out  ADDR_W  next slot to be written.

## Operation
- Input sync: KEY_N passes through two flops, both reset to 1 (released).
- Debounce:
  - key_db is a registered debounced level, reset value 1.
  - A counter increments each cycle that the synced level differs from key_db. It clears to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1, key_db takes the synced value and the counter clears.
- Press event: a 1→0 transition of key_db generates a single-cycle event. Releases generate nothing.
- FSM states: IDLE, WRITE, READ, CHECK.
  - IDLE: on a press event, latch SW into data_r and go to WRITE. Otherwise stay.
  - WRITE: mem_wren=1, mem_addr=wr_ptr, mem_data=data_r. Go to READ.
  - READ: mem_wren=0, mem_addr=wr_ptr held. Go to CHECK.
  - CHECK: compare mem_q with data_r, then go to IDLE.
    - On match: pulse done next cycle and set wr_ptr ← wr_ptr+1, modulo 2^ADDR_W. If wr_ptr was 2^ADDR_W−1, set full.
    - On mismatch: set error. wr_ptr is unchanged, so the next press retries the same slot.
- Press events while busy are dropped, not queued.
- After wrap, writing continues from slot 0 and overwrites old entries. full stays set.
- error and full clear only on reset.
- mem_addr equals wr_ptr at all times. mem_data equals data_r at all times.

## Timing
- Let cycle T be the first cycle in which key_db=0.
  - T+1: state=WRITE, mem_wren=1, busy=1.
  - T+2: state=READ.
  - T+3: state=CHECK.
  - T+4: state=IDLE, busy=0, plus done=1 and wr_ptr updated (match) or error=1 (mismatch).
- Write-to-done latency is 4 cycles from the debounced edge. The minimum press-to-done latency from a KEY_N edge is 2 sync cycles + DEBOUNCE_CYCLES + 4.
- mem_wren is high for exactly one cycle per accepted press.
- Reset values: mem_wren=0, mem_addr=0, mem_data=0, busy=0, done=0, error=0, full=0, wr_ptr=0, state=IDLE, key_db=1, debounce counter=0.
- Reset mid-operation: state→IDLE and mem_wren=0 in the next cycle. An interrupted slot may hold the new data; the RAM is not cleared.
- Bounce shorter than DEBOUNCE_CYCLES must produce no event. A level that is stable for exactly DEBOUNCE_CYCLES cycles must produce an event.
- A SW change after the press cycle does not affect the in-flight write.

## Test plan
- Basic write: DEBOUNCE_CYCLES=4, SW=0xA5, clean press → exactly one mem_wren pulse at addr 0 with data 0xA5, done at T+4, wr_ptr=1, error=0.
- Bounce: toggle KEY_N every 2 cycles for 20 cycles, then hold low → exactly one write. Glitches of 3 cycles alone → no write.
- Wrap: 9 presses with SW=1..9 and ADDR_W=3 → slots 0..7 hold 1..8, the ninth write goes to slot 0 with value 9, full=1 after the eighth done, wr_ptr=1 at the end.
- Mismatch: the RAM model forces mem_q=0x00 for a press with SW=0x3C → error=1 at T+4, no done, wr_ptr unchanged. The next press rewrites the same slot.
- Busy drop: inject a second debounced press during WRITE/READ → only one write occurs.
- Reset mid-write: assert reset in the cycle mem_wren=1 → the next cycle has mem_wren=0, busy=0, wr_ptr=0, and all flags are 0.

Source files
------------

// File: rtl/speed_table_writer.sv
// Debounced KEY press captures SW into the next table slot, then reads it back and
// reports done (match) or a sticky error (mismatch); write pointer wraps and sets full.
module speed_table_writer #(
   parameter int ADDR_W          = 3,
   parameter int DATA_W          = 8,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              KEY_N,
   input  logic [DATA_W-1:0] SW,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              full,
   output logic [ADDR_W-1:0] wr_ptr
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CHECK
   } state_e;

   state_e              state_q, state_d;
   logic                key_meta_q, key_sync_q;
   logic                key_db_q, key_db_d, key_db_prev_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                press_event;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                full_q, full_d;
   logic                match;

   // Debounced level only follows the synced key after DEBOUNCE_CYCLES unbroken cycles of disagreement.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      cnt_d    = '0;
      key_db_d = key_db_q;
      if (key_sync_q != key_db_q) begin
         if (cnt_q == CNT_LAST) begin
            key_db_d = key_sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign press_event = key_db_prev_q && !key_db_q;
   assign match       = (mem_q == data_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (press_event) state_d = S_WRITE;
         S_WRITE: state_d = S_READ;
         S_READ:  state_d = S_CHECK;
         S_CHECK: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_wren = (state_q == S_WRITE);
      busy     = (state_q != S_IDLE);
   end

   // Presses arriving while busy are simply ignored: data is only latched from IDLE.
   always_comb begin
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      done_d   = 1'b0;
      error_d  = error_q;
      full_d   = full_q;
      if (state_q == S_IDLE && press_event) begin
         data_d = SW;
      end
      if (state_q == S_CHECK) begin
         if (match) begin
            done_d   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (wr_ptr_q == '1) full_d = 1'b1;
         end else begin
            error_d = 1'b1;
         end
      end
   end

   // NOTE: the table RAM lives outside this block and is never cleared; only pointer, flags and FSM restart.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= S_IDLE;
         key_meta_q    <= 1'b1;
         key_sync_q    <= 1'b1;
         key_db_q      <= 1'b1;
         key_db_prev_q <= 1'b1;
         cnt_q         <= '0;
         data_q        <= '0;
         wr_ptr_q      <= '0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         full_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values, like real flops.
         state_q       <= state_d;
         key_meta_q    <= KEY_N;
         key_sync_q    <= key_meta_q;
         key_db_q      <= key_db_d;
         key_db_prev_q <= key_db_q;
         cnt_q         <= cnt_d;
         data_q        <= data_d;
         wr_ptr_q      <= wr_ptr_d;
         done_q        <= done_d;
         error_q       <= error_d;
         full_q        <= full_d;
      end
   end

   assign mem_addr = wr_ptr_q;
   assign mem_data = data_q;
   assign wr_ptr   = wr_ptr_q;
   assign done     = done_q;
   assign error    = error_q;
   assign full     = full_q;

endmodule

// File: tb/tb_speed_table_writer.sv
// Directed sequence with random SW values, a behavioural table/pointer model and a
// registered-address RAM; every observation is an immediate assertion.
module tb_speed_table_writer;

   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 8;
   localparam int DEB      = 4;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam int LAT_WREN = 2 + DEB + 1;
   localparam int LAT_DONE = 2 + DEB + 4;
   localparam int SETTLE   = 2 + DEB + 2;

   logic              CLOCK_50 = 1'b0;
   logic              reset;
   logic              KEY_N;
   logic [DATA_W-1:0] SW;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;
   logic              busy, done, error, full;
   logic [ADDR_W-1:0] wr_ptr;

   always #10 CLOCK_50 = ~CLOCK_50;

   speed_table_writer #(
      .ADDR_W          (ADDR_W),
      .DATA_W          (DATA_W),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .KEY_N    (KEY_N),
      .SW       (SW),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wren (mem_wren),
      .mem_q    (mem_q),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .full     (full),
      .wr_ptr   (wr_ptr)
   );

   // Single-port RAM: registered address, unregistered read data.
   logic [DATA_W-1:0] ram [DEPTH];
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_zero;

   always @(posedge CLOCK_50) begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      ram_addr_q <= mem_addr;
   end
   assign mem_q = ram_zero ? '0 : ram[ram_addr_q];

   int n_checks = 0;
   int n_pass   = 0;
   int wren_cnt = 0;
   int done_cnt = 0;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_data;

   logic [DATA_W-1:0] exp_table [DEPTH];
   bit                exp_valid [DEPTH];
   int                exp_ptr = 0;
   bit                exp_full = 1'b0;
   bit                exp_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge CLOCK_50);
      if (mem_wren) begin
         wren_cnt++;
         last_addr = mem_addr;
         last_data = mem_data;
      end
      if (done) done_cnt++;
   endtask

   // Successful write: slot takes the value, pointer advances modulo DEPTH, last slot sets full.
   task automatic model_write(input logic [DATA_W-1:0] v);
      exp_table[exp_ptr] = v;
      exp_valid[exp_ptr] = 1'b1;
      if (exp_ptr == DEPTH - 1) exp_full = 1'b1;
      exp_ptr = (exp_ptr + 1) % DEPTH;
   endtask

   task automatic press(input logic [DATA_W-1:0] sw, input bit mm, input bit inject);
      int   wr_at      = -1;
      int   dn_at      = -1;
      int   w0         = wren_cnt;
      int   d0         = done_cnt;
      int   slot       = exp_ptr;
      bit   full_after = exp_full || (!mm && exp_ptr == DEPTH - 1);
      int   ptr_after  = mm ? exp_ptr : (exp_ptr + 1) % DEPTH;
      bit   err_after  = exp_err || mm;
      SW       = sw;
      ram_zero = mm;
      KEY_N    = 1'b0;
      for (int k = 1; k <= LAT_DONE + 2; k++) begin
         tick();
         if (mem_wren && wr_at < 0) wr_at = k;
         if (done && dn_at < 0) dn_at = k;
         if (k == LAT_WREN) begin
            check("write_addr", mem_addr, slot);
            check("write_data", mem_data, sw);
            check("busy_in_write", busy, 1);
            SW = ~sw;
            if (inject) force dut.press_event = 1'b1;
         end
         if (inject && k == LAT_WREN + 2) release dut.press_event;
         if (k == LAT_DONE) begin
            check("busy_at_done", busy, 0);
            check("done_pulse", done, !mm);
            check("error_flag", error, err_after);
            check("wr_ptr_at_done", wr_ptr, ptr_after);
         end
      end
      KEY_N    = 1'b1;
      ram_zero = 1'b0;
      repeat (SETTLE) tick();
      check("wren_cycle", wr_at, LAT_WREN);
      check("wren_count", wren_cnt - w0, 1);
      check("done_count", done_cnt - d0, mm ? 0 : 1);
      check("full_flag", full, full_after);
      if (mm) begin
         exp_table[slot] = sw;
         exp_valid[slot] = 1'b1;
         exp_err         = 1'b1;
      end else begin
         model_write(sw);
      end
      check("ram_slot", ram[slot], sw);
   endtask

   initial begin
      int                w0;
      int                d0;
      int                slot;
      bit                found;
      logic [DATA_W-1:0] v;

      reset    = 1'b1;
      KEY_N    = 1'b1;
      SW       = '0;
      ram_zero = 1'b0;
      repeat (3) tick();
      check("rst_wren", mem_wren, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_full", full, 0);
      check("rst_wr_ptr", wr_ptr, 0);
      reset = 1'b0;
      repeat (SETTLE) tick();

      press(8'hA5, 1'b0, 1'b0);

      // Bouncing every 2 cycles, then a solid hold: one write only.
      w0 = wren_cnt;
      d0 = done_cnt;
      slot = exp_ptr;
      v = 8'($urandom);
      SW = v;
      for (int i = 0; i < 10; i++) begin
         KEY_N = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         tick();
      end
      KEY_N = 1'b0;
      repeat (LAT_DONE + 2) tick();
      KEY_N = 1'b1;
      repeat (SETTLE) tick();
      check("bounce_wren_count", wren_cnt - w0, 1);
      check("bounce_done_count", done_cnt - d0, 1);
      check("bounce_addr", last_addr, slot);
      check("bounce_data", last_data, v);
      model_write(v);
      check("bounce_wr_ptr", wr_ptr, exp_ptr);

      // Glitches one cycle short of the debounce window are ignored.
      w0 = wren_cnt;
      repeat (2) begin
         SW = 8'($urandom);
         KEY_N = 1'b0;
         repeat (DEB - 1) tick();
         KEY_N = 1'b1;
         repeat (SETTLE) tick();
      end
      check("glitch_wren_count", wren_cnt - w0, 0);
      check("glitch_wr_ptr", wr_ptr, exp_ptr);

      // A low level lasting exactly the debounce window is accepted.
      w0 = wren_cnt;
      slot = exp_ptr;
      v = 8'($urandom);
      SW = v;
      KEY_N = 1'b0;
      repeat (DEB) tick();
      KEY_N = 1'b1;
      repeat (LAT_DONE + SETTLE) tick();
      check("exact_wren_count", wren_cnt - w0, 1);
      check("exact_data", last_data, v);
      model_write(v);
      check("exact_wr_ptr", wr_ptr, exp_ptr);

      // Forced readback mismatch, then a retry that must land in the same slot.
      press(8'h3C, 1'b1, 1'b0);
      press(8'($urandom), 1'b0, 1'b0);

      for (int i = 0; i < DEPTH + 1; i++) press(8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         if (exp_valid[i]) check("table_contents", ram[i], exp_table[i]);
      end

      press(8'($urandom), 1'b0, 1'b1);

      // Reset landing on the write cycle.
      v = 8'($urandom);
      SW = v;
      KEY_N = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 2 * LAT_DONE && !found; k++) begin
         tick();
         if (mem_wren) found = 1'b1;
      end
      check("rst_mid_reached_write", found, 1);
      reset = 1'b1;
      KEY_N = 1'b1;
      tick();
      check("rst_mid_wren", mem_wren, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_wr_ptr", wr_ptr, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_error", error, 0);
      check("rst_mid_full", full, 0);
      reset = 1'b0;
      exp_table[exp_ptr] = v;
      exp_valid[exp_ptr] = 1'b1;
      exp_ptr  = 0;
      exp_full = 1'b0;
      exp_err  = 1'b0;
      repeat (SETTLE) tick();
      press(8'($urandom), 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
